// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall (hold), flush (bubble), valid bit and saturating T_new decrement.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt / flush_cnt event counters.
module pipe_stage_reg #(
    parameter int          DATA_W   = 64,
    parameter int          TNEW_W   = 8,
    parameter int          TNEW_DEC = 1,
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter logic [7:0]  NOP_TYPE = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [31:0]       pc_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [4:0]        wr_in,
    input  logic              reg_write_in,
    input  logic [7:0]        instr_type_in,
    input  logic [TNEW_W-1:0] tnew_in,
    output logic              valid_out,
    output logic [31:0]       pc_out,
    output logic [DATA_W-1:0] data_out,
    output logic [4:0]        wr_out,
    output logic              reg_write_out,
    output logic [7:0]        instr_type_out,
    output logic [TNEW_W-1:0] tnew_out
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam logic [TNEW_W-1:0] DEC = TNEW_W'(TNEW_DEC);

    // Compare before subtracting so a young instruction never wraps to a huge T_new.
    logic [TNEW_W-1:0] tnew_next;
    always_comb begin
        tnew_next = '0;
        if (tnew_in > DEC) begin
            tnew_next = tnew_in - DEC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out      <= 1'b0;
            pc_out         <= RESET_PC;
            data_out       <= '0;
            wr_out         <= '0;
            reg_write_out  <= 1'b0;
            instr_type_out <= NOP_TYPE;
            tnew_out       <= '0;
        end else if (flush) begin
            // A bubble keeps the PC of the slot it replaced.
            valid_out      <= 1'b0;
            pc_out         <= pc_in;
            data_out       <= '0;
            wr_out         <= '0;
            reg_write_out  <= 1'b0;
            instr_type_out <= NOP_TYPE;
            tnew_out       <= '0;
        end else if (!stall) begin
            valid_out      <= valid_in;
            pc_out         <= pc_in;
            data_out       <= data_in;
            wr_out         <= wr_in;
            reg_write_out  <= reg_write_in;
            instr_type_out <= instr_type_in;
            tnew_out       <= tnew_next;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !flush && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, load/decrement, stall, flush, back-to-back and async reset.
// Counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] pc_in = '0;
    logic [63:0] data_in = '0;
    logic [4:0]  wr_in = '0;
    logic        reg_write_in = 1'b0;
    logic [7:0]  instr_type_in = '0;
    logic [7:0]  tnew_in = '0;

    logic        v0, v1, rw0, rw1;
    logic [31:0] pc0, pc1;
    logic [63:0] d0, d1;
    logic [4:0]  w0, w1;
    logic [7:0]  it0, it1, tn0, tn1;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] sc0, fc0, sc1, fc1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.TNEW_DEC(1)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .data_in(data_in), .wr_in(wr_in),
        .reg_write_in(reg_write_in), .instr_type_in(instr_type_in), .tnew_in(tnew_in),
        .valid_out(v0), .pc_out(pc0), .data_out(d0), .wr_out(w0),
        .reg_write_out(rw0), .instr_type_out(it0), .tnew_out(tn0)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(sc0), .flush_cnt(fc0)
`endif
    );

    pipe_stage_reg #(.TNEW_DEC(0)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .data_in(data_in), .wr_in(wr_in),
        .reg_write_in(reg_write_in), .instr_type_in(instr_type_in), .tnew_in(tnew_in),
        .valid_out(v1), .pc_out(pc1), .data_out(d1), .wr_out(w1),
        .reg_write_out(rw1), .instr_type_out(it1), .tnew_out(tn1)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic v, input logic [31:0] pc,
                         input logic [63:0] d, input logic [4:0] w, input logic rw,
                         input logic [7:0] it, input logic [7:0] tn);
        stall = s; flush = f; valid_in = v; pc_in = pc; data_in = d;
        wr_in = w; reg_write_in = rw; instr_type_in = it; tnew_in = tn;
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] pc,
                           input logic [63:0] d, input logic [4:0] w, input logic rw,
                           input logic [7:0] it, input logic [7:0] tn);
        chk({tag, ".valid"}, 64'(v0), 64'(v));
        chk({tag, ".pc"}, 64'(pc0), 64'(pc));
        chk({tag, ".data"}, d0, d);
        chk({tag, ".wr"}, 64'(w0), 64'(w));
        chk({tag, ".reg_write"}, 64'(rw0), 64'(rw));
        chk({tag, ".type"}, 64'(it0), 64'(it));
        chk({tag, ".tnew"}, 64'(tn0), 64'(tn));
    endtask

    initial begin
        // Reset from power-up
        #2 reset = 1'b1;
        #1 chk_all("por", 1'b0, 32'h00003000, 64'h0, 5'd0, 1'b0, 8'h00, 8'h00);
        chk("por.dut1_pc", 64'(pc1), 64'h3000);
        tick(); tick();
        reset = 1'b0;

        // Load with decrement: 2 -> 1, no-decrement copy keeps 2
        drive(0, 0, 1, 32'h00003000, 64'h1111_2222_3333_4444, 5'd7, 1, 8'h12, 8'd2);
        tick();
        chk_all("load1", 1'b1, 32'h00003000, 64'h1111_2222_3333_4444, 5'd7, 1'b1, 8'h12, 8'd1);
        chk("load1.dut1_tnew", 64'(tn1), 64'd2);

        // tnew 0 saturates at 0
        drive(0, 0, 1, 32'h00003004, 64'hA5, 5'd3, 0, 8'h05, 8'd0);
        tick();
        chk("sat0.tnew", 64'(tn0), 64'd0);
        chk("sat0.dut1_tnew", 64'(tn1), 64'd0);

        // No-decrement instance passes 3 through
        drive(0, 0, 1, 32'h00003008, 64'h0, 5'd1, 1, 8'h01, 8'd3);
        tick();
        chk("dec0.dut1_tnew", 64'(tn1), 64'd3);
        chk("dec1.dut0_tnew", 64'(tn0), 64'd2);

        // Stall holds for 3 cycles while inputs change
        drive(0, 0, 1, 32'h00003004, 64'hBEEF, 5'd9, 1, 8'h22, 8'd3);
        tick();
        chk_all("stall.load", 1'b1, 32'h00003004, 64'hBEEF, 5'd9, 1'b1, 8'h22, 8'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 32'h00004000 + 32'(i), 64'(i), 5'(i), 0, 8'h33, 8'd7);
            tick();
            chk_all("stall.hold", 1'b1, 32'h00003004, 64'hBEEF, 5'd9, 1'b1, 8'h22, 8'd2);
            chk("stall.hold.dut1_tnew", 64'(tn1), 64'd3);
        end

        // Flush wins over stall
        drive(1, 1, 1, 32'h00003010, 64'hDEAD, 5'd31, 1, 8'h44, 8'd5);
        tick();
        chk_all("flush_stall", 1'b0, 32'h00003010, 64'h0, 5'd0, 1'b0, 8'h00, 8'd0);
        chk("flush_stall.dut1_tnew", 64'(tn1), 64'd0);

        // Back-to-back: A, bubble, B
        drive(0, 0, 1, 32'h00003020, 64'hAAAA, 5'd10, 1, 8'h0A, 8'd1);
        tick();
        chk_all("b2b.A", 1'b1, 32'h00003020, 64'hAAAA, 5'd10, 1'b1, 8'h0A, 8'd0);
        drive(0, 1, 1, 32'h00003024, 64'hCCCC, 5'd11, 1, 8'h0C, 8'd2);
        tick();
        chk_all("b2b.bubble", 1'b0, 32'h00003024, 64'h0, 5'd0, 1'b0, 8'h00, 8'd0);
        drive(0, 0, 1, 32'h00003028, 64'hBBBB, 5'd12, 1, 8'h0B, 8'd4);
        tick();
        chk_all("b2b.B", 1'b1, 32'h00003028, 64'hBBBB, 5'd12, 1'b1, 8'h0B, 8'd3);

        // Invalid slot captured verbatim, reg_write not masked
        drive(0, 0, 0, 32'h0000302C, 64'h77, 5'd5, 1, 8'h09, 8'd1);
        tick();
        chk_all("invalid", 1'b0, 32'h0000302C, 64'h77, 5'd5, 1'b1, 8'h09, 8'd0);

        // Glitch on stall between edges has no effect
        drive(0, 0, 1, 32'h00003030, 64'h55, 5'd6, 1, 8'h06, 8'd2);
        #2 stall = 1'b1;
        #2 stall = 1'b0;
        tick();
        chk("glitch.pc", 64'(pc0), 64'h3030);

        // Async reset mid-stall applies before the next edge
        drive(1, 0, 1, 32'h00005000, 64'h99, 5'd8, 1, 8'h08, 8'd6);
        #2 reset = 1'b1;
        #1 chk_all("rst_mid", 1'b0, 32'h00003000, 64'h0, 5'd0, 1'b0, 8'h00, 8'd0);
        tick();
        reset = 1'b0;
        tick();
        chk_all("rst_stall", 1'b0, 32'h00003000, 64'h0, 5'd0, 1'b0, 8'h00, 8'd0);
        drive(0, 0, 1, 32'h00003034, 64'h66, 5'd2, 1, 8'h07, 8'd3);
        tick();
        chk_all("rst_resume", 1'b1, 32'h00003034, 64'h66, 5'd2, 1'b1, 8'h07, 8'd2);

`ifdef PIPE_STAGE_PERF_EN
        // Counters: 5 stalls, 2 flushes, 1 both
        #2 reset = 1'b1;
        #1 chk("perf.rst_stall", 64'(sc0), 64'd0);
        chk("perf.rst_flush", 64'(fc0), 64'd0);
        tick();
        reset = 1'b0;
        drive(1, 0, 1, 32'h00003000, 64'h0, 5'd0, 0, 8'h00, 8'd0);
        for (int i = 0; i < 5; i++) tick();
        drive(0, 1, 1, 32'h00003000, 64'h0, 5'd0, 0, 8'h00, 8'd0);
        for (int i = 0; i < 2; i++) tick();
        drive(1, 1, 1, 32'h00003000, 64'h0, 5'd0, 0, 8'h00, 8'd0);
        tick();
        drive(0, 0, 1, 32'h00003000, 64'h0, 5'd0, 0, 8'h00, 8'd0);
        tick();
        chk("perf.stall_cnt", 64'(sc0), 64'd5);
        chk("perf.flush_cnt", 64'(fc0), 64'd3);
        // Run flush_cnt up to saturation, then one more
        drive(0, 1, 1, 32'h00003000, 64'h0, 5'd0, 0, 8'h00, 8'd0);
        for (int i = 0; i < 65532; i++) tick();
        chk("perf.flush_max", 64'(fc0), 64'hFFFF);
        tick();
        chk("perf.flush_sat", 64'(fc0), 64'hFFFF);
        chk("perf.stall_keep", 64'(sc0), 64'd5);
        drive(0, 0, 1, 32'h00003000, 64'h0, 5'd0, 0, 8'h00, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
